alarm_unit: RTL
===============

# alarm_unit

Alarm storage, editing and ringing stage directly downstream of the four-key controller. It consumes the controller's alarm-mode signals (`adjust_alarm`, `flip_state`, `select_add`, `alarm_add`, `alarm_clr`) and holds a BCD HH:MM alarm time plus an enable flag. It compares the alarm against the running clock's BCD time and drives a gated buzzer tone for a bounded ring period. Its outputs feed the seven-segment/LCD display path, including a blink mask for the digit being edited.

## Interface
- `CLK_HZ`, 50_000_000, clock frequency; sets the 1 Hz, blink and tone prescalers.
- `TONE_HZ`, 1000, buzzer square-wave frequency.
- `RING_SECONDS`, 60, maximum ring duration in seconds.
- `CLOCK_50  in  1`  system clock. This is the only clock.
- `reset  in  1`  synchronous, active-high reset.
- `adjust_alarm  in  1`  high while the controller is in alarm-adjust mode.
- `flip_state, select_add, alarm_add, alarm_clr  in  1 each`  request levels; each acts on its rising edge only.
- `hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units  in  4 each`  current time in BCD.
- `alarm_en  out  1`  alarm armed.
- `al_hour_tens, al_hour_units, al_min_tens, al_min_units  out  4 each`  stored alarm time in BCD.
- `sel  out  2`  edited digit: 0 = hour_tens, 1 = hour_units, 2 = min_tens, 3 = min_units.
- `blink_mask  out  4`  one-hot mask of the digit to blank, bit i corresponds to sel == i.
- `ring  out  1`  alarm is ringing.
- `buzzer  out  1`  gated tone output.

## Operation
- Each request input is edge-detected with a one-register delay. An event fires on a cycle where the input is 1 and its delayed copy is 0.
- Event priority within one cycle: flip > clr > add > select_add. Lower-priority events in the same cycle are dropped.
- Events are honoured only while `adjust_alarm` = 1. Otherwise they are ignored.
- flip toggles `alarm_en`.
- select_add advances `sel` as 0→1→2→3→0.
- clr writes 0 to the selected digit.
- add increments the selected digit with wrap:
  - hour_tens: 0..2.
  - hour_units: 0..9, or 0..3 when hour_tens = 2.
  - min_tens: 0..5.
  - min_units: 0..9.
- If hour_tens becomes 2 while hour_units > 3, hour_units is clamped to 3 in the same update.
- FSM states and transitions:
  - OFF (`alarm_en` = 0).
  - ARMED (`alarm_en` = 1, no ring). Goes to RINGING when `match` rises.
  - RINGING. Leaves on any of:
    - `adjust_alarm` high → ARMED;
    - a flip event → OFF;
    - the ring counter reaching RING_SECONDS → ARMED.
- `match` = `alarm_en` & !`adjust_alarm` & (HH:MM inputs equal the stored alarm) & sec_tens = 0 & sec_units = 0. It is registered.
- RINGING is entered only on the 0→1 transition of the registered `match`, so one minute boundary triggers exactly one ring.
- Ring seconds come from an internal 1 Hz tick prescaler, cleared on entry to RINGING.
- `buzzer` = tone (toggles every CLK_HZ/(2·TONE_HZ) cycles) AND beep gate (toggles every CLK_HZ/2 cycles, starting high), and only while `ring` = 1. Otherwise `buzzer` = 0.
- `blink_mask` = one-hot(`sel`) while `adjust_alarm` = 1 and the blink phase is low. The blink phase toggles every CLK_HZ/4 cycles. Otherwise `blink_mask` = 0.

## Timing
- Reset values:
  - `alarm_en` = 0, all alarm digits = 0, `sel` = 0;
  - `ring` = 0, `buzzer` = 0, `blink_mask` = 0;
  - FSM = OFF, all prescalers = 0, edge registers = 0.
- Reset asserted mid-ring or mid-edit returns every output to its reset value on the next edge.
- Edit latency: an input sampled high at edge N (having been low at N−1) updates the outputs at edge N+1.
- Match latency: the time inputs reach HH:MM:00 at edge N → registered `match` high at N+1 → `ring` high at N+2.
- A held request input produces one event; it must return low before the next event.
- `adjust_alarm` rising during RINGING clears `ring` on the next edge. The same cycle's edit events are still honoured.

## Structure
- Package `alarm_pkg`:
  - digit index constants HT/HU/MT/MU;
  - digit maxima (2, 9, 3, 5, 9);
  - FSM state enum {OFF, ARMED, RINGING}.
- Sub-module `alarm_tone_gen`, instantiated once. It contains:
  - the 1 Hz tick, tone and beep-gate prescalers, all cleared by `reset` and by a `start` pulse;
  - outputs `tick_1hz` and `tone_gated`.
- Main module contents: edge detection, digit editing, compare, FSM, blink counter.

## Test plan
All scenarios use CLK_HZ = 100, TONE_HZ = 10, RING_SECONDS = 3.
- Edit and wrap: adjust_alarm = 1; set hour_tens = 2 via add ×2, then sel = 1 with hour_units preset to 9 → hour_units reads 3; add → 0.
- Priority: flip and add rising in the same cycle with alarm_en = 0 → alarm_en = 1, selected digit unchanged. Events pulsed with adjust_alarm = 0 → no change.
- Match: alarm 07:30, enabled; drive time 07:29:59 → 07:30:00 → ring = 1 two edges after the time change. Buzzer toggles every 5 cycles during the first 50 cycles, then stays 0 for 50 cycles.
- Timeout: no intervention → ring falls after 300 cycles, state ARMED. Holding 07:30:00 for another 100 cycles produces no re-ring.
- Silence: ringing, then a flip event → ring = 0, alarm_en = 0 one edge later. Separately, raising adjust_alarm → ring = 0, alarm_en stays 1.
- Reset mid-ring: reset for 1 cycle → every output at its reset value, alarm time 00:00.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared constants and types for the alarm storage/ringing stage.
// Digit indices match the `sel` encoding seen by the display path.
package alarm_pkg;

  localparam logic [1:0] HT = 2'd0;
  localparam logic [1:0] HU = 2'd1;
  localparam logic [1:0] MT = 2'd2;
  localparam logic [1:0] MU = 2'd3;

  localparam logic [3:0] HT_MAX    = 4'd2;
  localparam logic [3:0] HU_MAX    = 4'd9;
  localparam logic [3:0] HU_MAX_20 = 4'd3;
  localparam logic [3:0] MT_MAX    = 4'd5;
  localparam logic [3:0] MU_MAX    = 4'd9;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2
  } alarm_state_e;

  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] max_v);
    return (v >= max_v) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// 1 Hz ring-second tick plus the gated buzzer tone (tone AND slow beep gate).
// All prescalers restart on `start` so every ring begins with the same pattern.
module alarm_tone_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TONE_HZ = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic tick_1hz,
  output logic tone_gated
);
  import alarm_pkg::*;

  localparam int CW        = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 2;
  localparam int TONE_HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int BEEP_HALF = CLK_HZ / 2;

  logic [CW-1:0] sec_cnt_q, sec_cnt_d;
  logic [CW-1:0] tone_cnt_q, tone_cnt_d;
  logic [CW-1:0] beep_cnt_q, beep_cnt_d;
  logic          tone_q, tone_d;
  logic          beep_q, beep_d;

  always_comb begin
    tick_1hz   = (sec_cnt_q == CW'(CLK_HZ - 1));
    sec_cnt_d  = tick_1hz ? '0 : sec_cnt_q + 1'b1;
    tone_cnt_d = tone_cnt_q + 1'b1;
    tone_d     = tone_q;
    beep_cnt_d = beep_cnt_q + 1'b1;
    beep_d     = beep_q;
    if (tone_cnt_q == CW'(TONE_HALF - 1)) begin
      tone_cnt_d = '0;
      tone_d     = ~tone_q;
    end
    if (beep_cnt_q == CW'(BEEP_HALF - 1)) begin
      beep_cnt_d = '0;
      beep_d     = ~beep_q;
    end
    tone_gated = tone_q & beep_q;
  end

  // Beep gate restarts high so a ring opens with an audible burst.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      sec_cnt_q  <= '0;
      tone_cnt_q <= '0;
      beep_cnt_q <= '0;
      tone_q     <= 1'b0;
      beep_q     <= 1'b1;
    end else begin
      sec_cnt_q  <= sec_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      beep_cnt_q <= beep_cnt_d;
      tone_q     <= tone_d;
      beep_q     <= beep_d;
    end
  end

endmodule

// File: rtl/alarm_unit.sv
// Alarm time storage/editing, minute-boundary compare and bounded ringing.
// Request inputs are sampled, then edge-detected; events act one edge later.
module alarm_unit #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TONE_HZ      = 1000,
  parameter int RING_SECONDS = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       adjust_alarm,
  input  logic       flip_state,
  input  logic       select_add,
  input  logic       alarm_add,
  input  logic       alarm_clr,
  input  logic [3:0] hour_tens,
  input  logic [3:0] hour_units,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_units,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_units,
  output logic       alarm_en,
  output logic [3:0] al_hour_tens,
  output logic [3:0] al_hour_units,
  output logic [3:0] al_min_tens,
  output logic [3:0] al_min_units,
  output logic [1:0] sel,
  output logic [3:0] blink_mask,
  output logic       ring,
  output logic       buzzer,
  output logic [1:0] state_dbg
);
  import alarm_pkg::*;

  localparam int CW   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 2;
  localparam int RS_W = (RING_SECONDS > 1) ? $clog2(RING_SECONDS + 1) : 1;

  // Request bit order everywhere: {flip, clr, add, select}.
  logic [3:0] req_s_q, req_d_q, rise;
  logic       ev_flip, ev_clr, ev_add, ev_sel;

  logic [3:0] ht_q, ht_d, hu_q, hu_d, mt_q, mt_d, mu_q, mu_d;
  logic [1:0] sel_q, sel_d;

  logic match_d, match_q, match_prev_q;
  alarm_state_e state_q, state_d;
  logic [RS_W-1:0] ring_sec_q, ring_sec_d;
  logic ring_start, tick_1hz, tone_gated;

  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [3:0]    blink_mask_q, blink_mask_d;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      req_s_q <= '0;
      req_d_q <= '0;
    end else begin
      req_s_q <= {flip_state, alarm_clr, alarm_add, select_add};
      req_d_q <= req_s_q;
    end
  end

  always_comb begin
    rise    = req_s_q & ~req_d_q;
    ev_flip = adjust_alarm & rise[3];
    ev_clr  = adjust_alarm & rise[2] & ~rise[3];
    ev_add  = adjust_alarm & rise[1] & ~(|rise[3:2]);
    ev_sel  = adjust_alarm & rise[0] & ~(|rise[3:1]);
  end

  always_comb begin
    ht_d  = ht_q;
    hu_d  = hu_q;
    mt_d  = mt_q;
    mu_d  = mu_q;
    sel_d = sel_q;
    if (ev_sel) sel_d = sel_q + 2'd1;
    if (ev_clr) begin
      case (sel_q)
        HT:      ht_d = 4'd0;
        HU:      hu_d = 4'd0;
        MT:      mt_d = 4'd0;
        default: mu_d = 4'd0;
      endcase
    end
    if (ev_add) begin
      case (sel_q)
        HT: begin
          ht_d = wrap_inc(ht_q, HT_MAX);
          // Keep the hour legal (<= 23) when tens steps up to 2.
          if (ht_d == HT_MAX && hu_q > HU_MAX_20) hu_d = HU_MAX_20;
        end
        HU:      hu_d = wrap_inc(hu_q, (ht_q == HT_MAX) ? HU_MAX_20 : HU_MAX);
        MT:      mt_d = wrap_inc(mt_q, MT_MAX);
        default: mu_d = wrap_inc(mu_q, MU_MAX);
      endcase
    end
  end

  assign alarm_en = (state_q != OFF);
  assign match_d  = alarm_en & ~adjust_alarm
                  & (hour_tens == ht_q) & (hour_units == hu_q)
                  & (min_tens == mt_q) & (min_units == mu_q)
                  & (sec_tens == 4'd0) & (sec_units == 4'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     if (ev_flip) state_d = ARMED;
      ARMED: begin
        if (ev_flip)                       state_d = OFF;
        else if (match_q && !match_prev_q) state_d = RINGING;
      end
      RINGING: begin
        if (ev_flip)           state_d = OFF;
        else if (adjust_alarm) state_d = ARMED;
        else if (tick_1hz && ring_sec_q == RS_W'(RING_SECONDS - 1)) state_d = ARMED;
      end
      default: state_d = OFF;
    endcase
    ring_start = (state_d == RINGING) && (state_q != RINGING);
    ring_sec_d = ring_sec_q;
    if (ring_start)                              ring_sec_d = '0;
    else if (state_q == RINGING && tick_1hz)     ring_sec_d = ring_sec_q + 1'b1;
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    if (blink_cnt_q == CW'(CLK_HZ / 4 - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
    blink_mask_d = (adjust_alarm && !blink_d) ? (4'b0001 << sel_d) : 4'b0000;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ht_q         <= '0;
      hu_q         <= '0;
      mt_q         <= '0;
      mu_q         <= '0;
      sel_q        <= '0;
      match_q      <= 1'b0;
      match_prev_q <= 1'b0;
      state_q      <= OFF;
      ring_sec_q   <= '0;
      blink_cnt_q  <= '0;
      blink_q      <= 1'b0;
      blink_mask_q <= '0;
    end else begin
      ht_q         <= ht_d;
      hu_q         <= hu_d;
      mt_q         <= mt_d;
      mu_q         <= mu_d;
      sel_q        <= sel_d;
      match_q      <= match_d;
      match_prev_q <= match_q;
      state_q      <= state_d;
      ring_sec_q   <= ring_sec_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_q      <= blink_d;
      blink_mask_q <= blink_mask_d;
    end
  end

  alarm_tone_gen #(
    .CLK_HZ (CLK_HZ),
    .TONE_HZ(TONE_HZ)
  ) u_tone (
    .clk       (CLOCK_50),
    .reset     (reset),
    .start     (ring_start),
    .tick_1hz  (tick_1hz),
    .tone_gated(tone_gated)
  );

  assign ring          = (state_q == RINGING);
  assign buzzer        = ring & tone_gated;
  assign blink_mask    = blink_mask_q;
  assign sel           = sel_q;
  assign al_hour_tens  = ht_q;
  assign al_hour_units = hu_q;
  assign al_min_tens   = mt_q;
  assign al_min_units  = mu_q;
  assign state_dbg     = state_q;

endmodule
